vga_mem_arbiter: RTL and testbench
==================================

VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12: pixel RAM address width.
REQ-002 Parameter DATA_W, default 8: pixel RAM data width.
REQ-003 Parameter STARVE_LIM, default 8, legal 1..255: cycles a pending CPU request may be denied before it takes priority.
REQ-004 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 disp_req  input  1  display fetch request; held with disp_addr until acked.
REQ-007 disp_addr  input  ADDR_W  display read address.
REQ-008 disp_ack  output  1  combinational; high in the cycle the display read is issued to RAM.
REQ-009 disp_valid  output  1  registered; one-cycle pulse, disp_data valid.
REQ-010 disp_data  output  DATA_W  registered display read data.
REQ-011 cpu_req  input  1  CPU access request; held with cpu_we/cpu_addr/cpu_wdata until acked.
REQ-012 cpu_we  input  1  1 = write, 0 = read.
REQ-013 cpu_addr  input  ADDR_W  CPU address.
REQ-014 cpu_wdata  input  DATA_W  CPU write data.
REQ-015 cpu_ack  output  1  combinational; high in the cycle the CPU access is issued.
REQ-016 cpu_rvalid  output  1  registered; one-cycle pulse for CPU reads only.
REQ-017 cpu_rdata  output  DATA_W  registered CPU read data.
REQ-018 mem_addr  output  ADDR_W  to single-port RAM (address registered inside RAM, output unregistered).
REQ-019 mem_wdata  output  DATA_W  RAM write data.
REQ-020 mem_we  output  1  RAM write enable.
REQ-021 mem_q  input  DATA_W  RAM read data, valid the cycle after the address is presented.
REQ-022 disp_stall_cnt  output  16  saturating count of cycles disp_req was high and not acked.

Function
REQ-023 At most one of disp_ack/cpu_ack SHALL be high per cycle; an ack is high only if its req is high.
REQ-024 Grant rule: if cpu_req and starve_cnt == STARVE_LIM -> CPU; else if disp_req -> display; else if cpu_req -> CPU; else none.
REQ-025 starve_cnt (8-bit) SHALL increment each cycle cpu_req=1 and cpu_ack=0, clear on cpu_ack=1 or cpu_req=0, and never exceed STARVE_LIM.
REQ-026 mem_addr/mem_wdata/mem_we SHALL be the combinational mux of the granted requester; with no grant mem_we=0, mem_addr=disp_addr, mem_wdata=0.
REQ-027 mem_we SHALL equal cpu_ack AND cpu_we; display accesses never write.
REQ-028 Read latency: ack high in cycle k -> mem_q sampled at end of cycle k+1 -> disp_valid/cpu_rvalid high in cycle k+2 only.
REQ-029 A 2-stage tag pipeline {valid, owner} SHALL route each read's data to exactly one of disp_data/cpu_rdata; back-to-back acks every cycle SHALL be supported with no loss.
REQ-030 CPU writes complete at the end of the ack cycle and SHALL NOT produce cpu_rvalid.
REQ-031 disp_data/cpu_rdata SHALL hold their last value when their valid is low.
REQ-032 disp_stall_cnt SHALL saturate at 16'hFFFF and not wrap.

Reset
REQ-033 While reset=1: disp_ack=0, cpu_ack=0, mem_we=0 (combinational override); on the edge: starve_cnt=0, tag pipeline cleared, disp_valid=0, cpu_rvalid=0, disp_data=0, cpu_rdata=0, disp_stall_cnt=0.
REQ-034 Reads acked within 2 cycles before reset SHALL NOT produce a valid pulse after reset deasserts.

Verification
REQ-035 Display only: disp_req=1, disp_addr=5, RAM[5]=8'hA3 -> disp_ack in cycle k, disp_valid=1 and disp_data=8'hA3 in cycle k+2 only.
REQ-036 CPU write then read: write 8'h5C to addr 9 (ack, mem_we=1), next cycle read addr 9 -> cpu_rvalid two cycles later with cpu_rdata=8'h5C; no cpu_rvalid for the write.
REQ-037 Starvation: disp_req and cpu_req held high, STARVE_LIM=8 -> display acked 8 consecutive cycles, CPU acked on the 9th, disp_stall_cnt increments by 1.
REQ-038 Interleaved reads: alternate disp/CPU acks each cycle -> every valid pulse appears on the correct port with correct data, none dropped or duplicated.
REQ-039 Reset mid-flight: disp_ack in cycle k, reset=1 in cycle k+1 -> disp_valid stays 0 in k+2 and after; all counters 0.
REQ-040 Saturation: disp_req=1 with CPU forced priority for 70000 stalled cycles -> disp_stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/vga_mem_arbiter.sv
// Arbiter between the display fetch path and the CPU for a single-port pixel RAM.
// The display wins by default. A CPU request that has been denied STARVE_LIM cycles
// in a row takes priority. Read data returns two cycles after the ack and is routed
// to the requester by a small {valid, owner} tag pipeline.
module vga_mem_arbiter #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned STARVE_LIM = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    // display fetch port
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ack,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    // CPU port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    // single-port RAM
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q,
    // statistics
    output logic [15:0]       disp_stall_cnt
);

    localparam logic [7:0] StarveLim = 8'(STARVE_LIM);

    logic [7:0]        starve_cnt_q, starve_cnt_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;
    logic              cpu_prio;

    // Tag stage 1: read issued last cycle, data on mem_q this cycle.
    logic              rd_vld_q, rd_vld_d;
    logic              rd_cpu_q, rd_cpu_d;

    // Tag stage 2: registered outputs to the requesters.
    logic              disp_valid_q, disp_valid_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

    // Grant: starved CPU first, then display, then CPU; nothing while in reset.
    always_comb begin
        disp_ack = 1'b0;
        cpu_ack  = 1'b0;
        cpu_prio = cpu_req && (starve_cnt_q == StarveLim);
        if (!reset) begin
            if (cpu_prio) begin
                cpu_ack = 1'b1;
            end else if (disp_req) begin
                disp_ack = 1'b1;
            end else if (cpu_req) begin
                cpu_ack = 1'b1;
            end
        end
    end

    // RAM port mux; idle cycles park the address on the display side.
    always_comb begin
        mem_addr  = disp_addr;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (cpu_ack) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
        end
    end

    // Next-state for the starvation and stall counters and the read-tag pipeline.
    always_comb begin
        starve_cnt_d = '0;
        if (cpu_req && !cpu_ack) begin
            starve_cnt_d = (starve_cnt_q < StarveLim) ? starve_cnt_q + 8'd1 : starve_cnt_q;
        end

        stall_cnt_d = stall_cnt_q;
        if (disp_req && !disp_ack && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end

        // CPU writes complete in the ack cycle and never enter the tag pipeline.
        rd_vld_d = disp_ack || (cpu_ack && !cpu_we);
        rd_cpu_d = cpu_ack;

        disp_valid_d = rd_vld_q && !rd_cpu_q;
        cpu_rvalid_d = rd_vld_q && rd_cpu_q;
        disp_data_d  = disp_valid_d ? mem_q : disp_data_q;
        cpu_rdata_d  = cpu_rvalid_d ? mem_q : cpu_rdata_q;
    end

    // State registers with synchronous reset; in-flight tags are dropped on reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            starve_cnt_q <= '0;
            stall_cnt_q  <= '0;
            rd_vld_q     <= 1'b0;
            rd_cpu_q     <= 1'b0;
            disp_valid_q <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            disp_data_q  <= '0;
            cpu_rdata_q  <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            rd_vld_q     <= rd_vld_d;
            rd_cpu_q     <= rd_cpu_d;
            disp_valid_q <= disp_valid_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            disp_data_q  <= disp_data_d;
            cpu_rdata_q  <= cpu_rdata_d;
        end
    end

    assign disp_valid     = disp_valid_q;
    assign cpu_rvalid     = cpu_rvalid_q;
    assign disp_data      = disp_data_q;
    assign cpu_rdata      = cpu_rdata_q;
    assign disp_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Randomised and directed bench for vga_mem_arbiter with a queue-based scoreboard.
module tb_vga_mem_arbiter;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned LIM    = 8;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              CLOCK_50 = 1'b0;
    logic              reset;
    logic              disp_req, disp_ack, disp_valid;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              cpu_req, cpu_we, cpu_ack, cpu_rvalid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_q;
    logic              mem_we;
    logic [15:0]       disp_stall_cnt;

    vga_mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_LIM(LIM)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .disp_req      (disp_req),
        .disp_addr     (disp_addr),
        .disp_ack      (disp_ack),
        .disp_valid    (disp_valid),
        .disp_data     (disp_data),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_ack       (cpu_ack),
        .cpu_rvalid    (cpu_rvalid),
        .cpu_rdata     (cpu_rdata),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_q         (mem_q),
        .disp_stall_cnt(disp_stall_cnt)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Single-port RAM: address registered, read data unregistered.
    logic [DATA_W-1:0] ram [DEPTH];
    logic [ADDR_W-1:0] ram_addr_q;
    always @(posedge CLOCK_50) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        ram_addr_q <= mem_addr;
    end
    assign mem_q = ram[ram_addr_q];

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state.
    typedef struct {
        bit                is_cpu;
        logic [DATA_W-1:0] data;
        int                due;
    } rd_t;
    rd_t               sb[$];
    logic [DATA_W-1:0] shadow [DEPTH];
    logic [DATA_W-1:0] last_disp = '0;
    logic [DATA_W-1:0] last_cpu  = '0;
    int                m_starve  = 0;
    int                m_stall   = 0;
    bit                m_force   = 1'b0;
    bit                g_disp    = 1'b0;
    bit                g_cpu     = 1'b0;
    bit                a_cpu_ack = 1'b0;
    bit                mon_en    = 1'b0;

    // Monitor: every valid pulse must match the head of the scoreboard on time.
    always @(negedge CLOCK_50) begin
        rd_t e;
        if (mon_en) begin
            chk("valid_exclusive", 32'(disp_valid & cpu_rvalid), 32'd0);
            if (disp_valid || cpu_rvalid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: disp_valid=%0b cpu_rvalid=%0b, expected none (cycle %0d)",
                             disp_valid, cpu_rvalid, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("rd_port_is_cpu", 32'(cpu_rvalid), 32'(e.is_cpu));
                    chk("rd_cycle", 32'(cyc), 32'(e.due));
                    if (e.is_cpu) last_cpu = e.data;
                    else          last_disp = e.data;
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_valid: got no pulse, expected %s data 0x%0h (cycle %0d)",
                         sb[0].is_cpu ? "cpu" : "disp", sb[0].data, cyc);
                sb.delete(0);
            end
            chk("disp_data", 32'(disp_data), 32'(last_disp));
            chk("cpu_rdata", 32'(cpu_rdata), 32'(last_cpu));
        end
    end

    // One clock of stimulus: inputs already driven; predict grant and update the model.
    task automatic model_cycle();
        bit ec, ed;
        @(negedge CLOCK_50);
        if (m_force) m_starve = LIM;
        ec = cpu_req && ((m_starve == LIM) || !disp_req);
        ed = disp_req && !ec;
        a_cpu_ack = cpu_ack;
        chk("disp_ack", 32'(disp_ack), 32'(ed));
        chk("cpu_ack", 32'(cpu_ack), 32'(ec));
        chk("mem_we", 32'(mem_we), 32'(ec && cpu_we));
        chk("mem_addr", 32'(mem_addr), ec ? 32'(cpu_addr) : 32'(disp_addr));
        chk("mem_wdata", 32'(mem_wdata), ec ? 32'(cpu_wdata) : 32'd0);
        chk("disp_stall_cnt", 32'(disp_stall_cnt), 32'(m_stall));
        if (ed) sb.push_back('{1'b0, shadow[disp_addr], cyc + 2});
        if (ec && !cpu_we) sb.push_back('{1'b1, shadow[cpu_addr], cyc + 2});
        if (ec && cpu_we) shadow[cpu_addr] = cpu_wdata;
        if (cpu_req && !ec) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
        else                m_starve = 0;
        if (disp_req && !ed && m_stall < 65535) m_stall++;
        g_disp = ed;
        g_cpu  = ec;
        @(posedge CLOCK_50);
        #1;
    endtask

    // One reset cycle with requests active; acks and writes must stay blocked.
    task automatic do_reset();
        reset    = 1'b1;
        disp_req = 1'b1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        @(negedge CLOCK_50);
        chk("reset_disp_ack", 32'(disp_ack), 32'd0);
        chk("reset_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        while (sb.size() != 0 && sb[sb.size()-1].due > cyc) sb.delete(sb.size() - 1);
        @(posedge CLOCK_50);
        #1;
        reset     = 1'b0;
        disp_req  = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        m_starve  = 0;
        m_stall   = 0;
        m_force   = 1'b0;
        g_disp    = 1'b0;
        g_cpu     = 1'b0;
        last_disp = '0;
        last_cpu  = '0;
    endtask

    initial begin
        int first_cpu;
        int stall0;

        for (int i = 0; i < DEPTH; i++) begin
            ram[i]    = DATA_W'($urandom);
            shadow[i] = ram[i];
        end
        ram[5]    = 8'hA3;
        shadow[5] = 8'hA3;

        reset     = 1'b1;
        disp_req  = 1'b0;
        disp_addr = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        do_reset();
        mon_en = 1'b1;

        // Display-only read of address 5.
        disp_req  = 1'b1;
        disp_addr = 5;
        model_cycle();
        disp_req = 1'b0;
        repeat (3) model_cycle();
        chk("disp_data_a3", 32'(disp_data), 32'h00A3);

        // CPU write then read-back of address 9.
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 9;
        cpu_wdata = 8'h5C;
        model_cycle();
        cpu_we = 1'b0;
        model_cycle();
        cpu_req = 1'b0;
        repeat (3) model_cycle();
        chk("cpu_rdata_5c", 32'(cpu_rdata), 32'h005C);

        // Starvation: display holds the port for LIM cycles, then the CPU gets in.
        model_cycle();
        stall0    = m_stall;
        first_cpu = -1;
        disp_req  = 1'b1;
        disp_addr = ADDR_W'($urandom_range(0, 15));
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = ADDR_W'($urandom_range(0, 15));
        for (int i = 0; i < 9; i++) begin
            model_cycle();
            if (a_cpu_ack && first_cpu < 0) first_cpu = i;
            if (g_disp) disp_addr = ADDR_W'($urandom_range(0, 15));
        end
        chk("starve_first_cpu_ack", 32'(first_cpu), 32'(LIM));
        chk("starve_stall_inc", 32'(disp_stall_cnt), 32'(stall0 + 1));
        disp_req = 1'b0;
        cpu_req  = 1'b0;
        repeat (3) model_cycle();

        // Interleaved single-requester reads, one ack per cycle.
        for (int i = 0; i < 12; i++) begin
            disp_req  = (i % 2 == 0);
            cpu_req   = (i % 2 == 1);
            cpu_we    = 1'b0;
            disp_addr = ADDR_W'($urandom_range(0, 31));
            cpu_addr  = ADDR_W'($urandom_range(0, 31));
            model_cycle();
        end
        disp_req = 1'b0;
        cpu_req  = 1'b0;
        repeat (3) model_cycle();

        // Reset while a display read is in flight.
        disp_req  = 1'b1;
        disp_addr = ADDR_W'($urandom_range(0, 15));
        model_cycle();
        do_reset();
        repeat (4) model_cycle();

        // Random traffic with hold-until-ack requesters and one mid-run reset.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            if (!disp_req || g_disp) begin
                disp_req  = ($urandom_range(0, 9) < 6);
                disp_addr = ADDR_W'($urandom_range(0, 15));
            end
            if (!cpu_req || g_cpu) begin
                cpu_req   = ($urandom_range(0, 9) < 5);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = ADDR_W'($urandom_range(0, 15));
                cpu_wdata = DATA_W'($urandom);
            end
            model_cycle();
        end
        disp_req = 1'b0;
        cpu_req  = 1'b0;
        repeat (3) model_cycle();

        // Stall counter saturation with the CPU pinned at priority.
        disp_req  = 1'b1;
        disp_addr = 3;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 7;
        cpu_wdata = 8'h11;
        force dut.starve_cnt_q = 8'(LIM);
        m_force = 1'b1;
        repeat (70000) model_cycle();
        chk("stall_saturated", 32'(disp_stall_cnt), 32'h0000FFFF);
        release dut.starve_cnt_q;
        do_reset();
        repeat (4) model_cycle();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
